// File: rtl/mem_lsu.sv
// Load/store unit: single outstanding data-bus access with writeback retirement.
// Upstream holds its inputs while stall_o is high; only IDLE samples them.
module mem_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [31:0] inst_i,
   input  logic        reg_w_ena_i,
   input  logic [4:0]  reg_w_addr_i,
   input  logic [31:0] reg_w_data_i,
   input  logic        mem_r_ena_i,
   input  logic [31:0] mem_r_addr_i,
   input  logic        mem_w_ena_i,
   input  logic [31:0] mem_w_addr_i,
   input  logic [31:0] mem_w_data_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic        wb_valid_o,
   output logic        wb_reg_w_ena_o,
   output logic [4:0]  wb_reg_w_addr_o,
   output logic [31:0] wb_reg_w_data_o,
   output logic        stall_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q, rd_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_ena_q, wb_ena_d;
   logic [4:0]  wb_addr_q, wb_addr_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;

   logic        is_access, is_store, supported, misaligned, legal;
   logic [2:0]  funct3;
   logic [31:0] acc_addr;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_shifted, ld_data;

   // Decode the upstream slot; a slot with both enables is a store.
   always_comb begin
      funct3    = inst_i[14:12];
      is_access = valid_i & (mem_r_ena_i | mem_w_ena_i);
      is_store  = mem_w_ena_i;
      acc_addr  = is_store ? mem_w_addr_i : mem_r_addr_i;
      if (is_store) begin
         supported = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
      end else begin
         supported = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                     (funct3 == 3'b100) | (funct3 == 3'b101);
      end
      misaligned = supported &
                   (((funct3[1:0] == 2'b01) & acc_addr[0]) |
                    ((funct3[1:0] == 2'b10) & (acc_addr[1:0] != 2'b00)));
      legal = supported & ~misaligned;
   end

   // Store lane steering: replicate narrow data so any enabled lane carries it.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = mem_w_data_i;
      case (funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << acc_addr[1:0];
            st_wdata = {4{mem_w_data_i[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << {acc_addr[1], 1'b0};
            st_wdata = {2{mem_w_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction from the returned word using the latched byte lane.
   always_comb begin
      ld_shifted = bus_rdata_i >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
         3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
         3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
         3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
         default: ld_data = bus_rdata_i;
      endcase
   end

   // FSM next-state, retirement and stall generation.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      we_d       = we_q;
      funct3_d   = funct3_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_ena_d   = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      misalign_d = 1'b0;
      stall_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (valid_i) begin
               if (!is_access) begin
                  wb_valid_d = 1'b1;
                  wb_ena_d   = reg_w_ena_i;
                  wb_addr_d  = reg_w_addr_i;
                  wb_data_d  = reg_w_data_i;
               end else if (legal) begin
                  addr_d   = acc_addr;
                  wdata_d  = st_wdata;
                  be_d     = is_store ? st_be : 4'b1111;
                  we_d     = is_store;
                  funct3_d = funct3;
                  rd_d     = reg_w_addr_i;
                  stall_o  = 1'b1;
                  state_d  = StReq;
               end else begin
                  // Faulting access retires as a no-op without touching the bus.
                  wb_valid_d = 1'b1;
                  wb_addr_d  = reg_w_addr_i;
                  wb_data_d  = 32'h0;
                  misalign_d = misaligned;
               end
            end
         end
         StReq: begin
            stall_o = 1'b1;
            if (bus_gnt_i) begin
               if (we_q) begin
                  stall_o    = 1'b0;
                  wb_valid_d = 1'b1;
                  wb_addr_d  = rd_q;
                  wb_data_d  = 32'h0;
                  state_d    = StIdle;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            stall_o = 1'b1;
            if (bus_rvalid_i) begin
               stall_o    = 1'b0;
               wb_valid_d = 1'b1;
               wb_ena_d   = 1'b1;
               wb_addr_d  = rd_q;
               wb_data_d  = ld_data;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (rst) begin
         stall_o = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         be_q       <= 4'h0;
         we_q       <= 1'b0;
         funct3_q   <= 3'h0;
         rd_q       <= 5'h0;
         wb_valid_q <= 1'b0;
         wb_ena_q   <= 1'b0;
         wb_addr_q  <= 5'h0;
         wb_data_q  <= 32'h0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         we_q       <= we_d;
         funct3_q   <= funct3_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_ena_q   <= wb_ena_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus_req_o       = (state_q == StReq);
   assign bus_we_o        = we_q;
   assign bus_addr_o      = {addr_q[31:2], 2'b00};
   assign bus_wdata_o     = wdata_q;
   assign bus_be_o        = be_q;
   assign wb_valid_o      = wb_valid_q;
   assign wb_reg_w_ena_o  = wb_ena_q;
   assign wb_reg_w_addr_o = wb_addr_q;
   assign wb_reg_w_data_o = wb_data_q;
   assign misalign_o      = misalign_q;

endmodule
